xor_share_arb: RTL and testbench

Shared-resource controller for one `width`-bit bitwise XOR datapath, time-multiplexed between `nreq` requesters. Arbitration is round-robin. The block holds one registered result slot and produces it on a valid/ready output port. It sits between multiple client blocks that each need occasional XOR operations and a single XOR unit, so the design instantiates one XOR datapath instead of `nreq`.

---
 rtl/xor_share_arb.sv | 92 +++++++++
 tb/tb_xor_share_arb.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/xor_share_arb.sv
// Round-robin arbiter sharing one XOR datapath among nreq requesters.
// A single registered result slot is offered on a valid/ready port.
module xor_share_arb #(
    parameter int unsigned width = 4,
    parameter int unsigned nreq  = 4,
    parameter int unsigned idw   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [nreq-1:0]       req,
    input  logic [nreq*width-1:0] opa,
    input  logic [nreq*width-1:0] opb,
    output logic [nreq-1:0]       gnt,
    output logic [width-1:0]      res,
    output logic [idw-1:0]        res_id,
    output logic                  res_valid,
    input  logic                  res_ready
);

    typedef enum logic [0:0] {StIdle, StFull} state_e;

    state_e           state_q, state_d;
    logic [idw-1:0]   ptr_q, ptr_d;
    logic [width-1:0] res_q;
    logic [idw-1:0]   res_id_q;
    logic             slot_free;
    logic             grant_en;
    logic [nreq-1:0]  masked;
    logic [idw-1:0]   win;
    logic [width-1:0] sel_a, sel_b;
    int               off;
    int               w_int;

    // Rotate requests so bit j means requester (ptr + j) mod nreq.
    always_comb begin
        masked = nreq'({req, req} >> ptr_q);
        off    = 0;
        for (int j = nreq - 1; j >= 0; j--) begin
            if (masked[j]) begin
                off = j;
            end
        end
        w_int = int'(ptr_q) + off;
        if (w_int >= int'(nreq)) begin
            w_int = w_int - int'(nreq);
        end
        win   = idw'(w_int);
        ptr_d = (w_int == int'(nreq) - 1) ? '0 : idw'(w_int + 1);
        sel_a = width'(opa >> (width * win));
        sel_b = width'(opb >> (width * win));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (grant_en) begin
            state_d = StFull;
        end else if (state_q == StFull && res_ready) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        slot_free = (state_q == StIdle) | res_ready;
        grant_en  = slot_free & (|req) & ~rst;
        gnt       = grant_en ? (nreq'(1) << win) : '0;
        res_valid = (state_q == StFull);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            res_q    <= '0;
            res_id_q <= '0;
        end else if (grant_en) begin
            ptr_q    <= ptr_d;
            res_q    <= sel_a ^ sel_b;
            res_id_q <= win;
        end
    end

    assign res    = res_q;
    assign res_id = res_id_q;

endmodule

// File: tb/tb_xor_share_arb.sv
// Directed plus randomized bench for xor_share_arb against a behavioural model.
module tb_xor_share_arb;

    localparam int W = 4;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] opa, opb;
    logic [N-1:0]   gnt;
    logic [W-1:0]   res;
    logic [1:0]     res_id;
    logic           res_valid;
    logic           res_ready;

    int checks   = 0;
    int failures = 0;

    // Model state: slot occupancy, search start, last result.
    int m_full = 0;
    int m_ptr  = 0;
    int m_res  = 0;
    int m_id   = 0;

    always #5 clk = ~clk;

    xor_share_arb #(.width(W), .nreq(N), .idw(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .opa      (opa),
        .opb      (opb),
        .gnt      (gnt),
        .res      (res),
        .res_id   (res_id),
        .res_valid(res_valid),
        .res_ready(res_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare against the model mid-cycle, then advance the model.
    task automatic tick(input int lit_gnt);
        int w;
        int exp_gnt;
        @(negedge clk);
        w = -1;
        exp_gnt = 0;
        if (!rst && (m_full == 0 || res_ready)) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (w < 0 && req[k]) w = k;
            end
        end
        if (w >= 0) exp_gnt = 1 << w;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        if (lit_gnt >= 0) chk("gnt_lit", 32'(gnt), 32'(lit_gnt));
        chk("res_valid", 32'(res_valid), 32'(m_full));
        chk("res", 32'(res), 32'(m_res));
        chk("res_id", 32'(res_id), 32'(m_id));
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_ptr = 0; m_res = 0; m_id = 0;
        end else if (w >= 0) begin
            m_res  = ((int'(opa) >> (w * W)) ^ (int'(opb) >> (w * W))) & ((1 << W) - 1);
            m_id   = w;
            m_full = 1;
            m_ptr  = (w + 1) % N;
        end else if (m_full != 0 && res_ready) begin
            m_full = 0;
        end
        #1;
    endtask

    initial begin
        // Reset with everything requesting
        rst = 1'b1; req = 4'b1111; res_ready = 1'b1; opa = 16'h1234; opb = 16'h5678;
        tick(0);
        tick(0);
        rst = 1'b0; req = 4'b0000;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);

        // Single operation from requester 1
        req = 4'b0010; opa = 16'h00A0; opb = 16'h0060;
        tick(4'b0010);
        req = 4'b0000;
        chk("single_valid", 32'(res_valid), 32'd1);
        chk("single_res", 32'(res), 32'hC);
        chk("single_id", 32'(res_id), 32'd1);
        tick(0);

        // Fairness and back-to-back throughput from a fresh pointer
        rst = 1'b1;
        tick(0);
        rst = 1'b0; req = 4'b1111; opa = 16'h9C3F; opb = 16'h5A17;
        for (int i = 0; i < 5; i++) begin
            tick(1 << (i % 4));
            chk("fair_id", 32'(res_id), 32'(i % 4));
            chk("fair_valid", 32'(res_valid), 32'd1);
        end

        // Backpressure: slot full, consumer stalled
        res_ready = 1'b0; req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick(0);
            chk("bp_id_hold", 32'(res_id), 32'd0);
        end
        res_ready = 1'b1;
        tick(4'b0100);
        chk("bp_new_id", 32'(res_id), 32'd2);
        chk("bp_new_res", 32'(res), 32'(4'hC ^ 4'hA));

        // Wrap past the top and skip idle requesters
        req = 4'b0101;
        tick(4'b0001);
        tick(4'b0100);
        req = 4'b0000;
        tick(0);
        chk("accept_idle", 32'(res_valid), 32'd0);
        req = 4'b1111;
        tick(4'b1000);

        // Reset in the middle of a pending result
        req = 4'b0010;
        tick(4'b0010);
        rst = 1'b1; req = 4'b1111;
        tick(0);
        rst = 1'b0; req = 4'b0000;
        chk("midrst_valid", 32'(res_valid), 32'd0);
        req = 4'b1111;
        tick(4'b0001);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req       = 4'($urandom());
            opa       = 16'($urandom());
            opb       = 16'($urandom());
            res_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 39) == 0);
            tick(-1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
